// File: rtl/first_counter_pkg.sv
// Shared definitions for the first_counter block: default width and count type.
package first_counter_pkg;

    // Default counter width in bits; any value of 1 or more is legal.
    localparam int FIRST_COUNTER_WIDTH_DEFAULT = 4;

    // Count value at the default width.
    typedef logic [FIRST_COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage : first_counter_pkg

// File: rtl/first_counter_core.sv
// Width-parameterised count register and incrementer.
// Exposes the registered count, the value it moves to on the next edge, and
// the carry out of the increment (high when the count is all-ones).
module first_counter_core
    import first_counter_pkg::*;
#(
    parameter int WIDTH = FIRST_COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_next_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;

    // One extra bit on the adder keeps the carry that the truncated count drops.
    assign sum = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

    // Next count: increment modulo 2^WIDTH when enabled, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (enable_i) begin
            count_d = sum[WIDTH-1:0];
        end
    end

    // Count register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign carry_o      = sum[WIDTH];

endmodule : first_counter_core

// File: rtl/first_counter.sv
// Free-running, enable-gated up-counter with a one-cycle wrap pulse.
// overflow_out is high for exactly the cycle in which counter_out reads 0
// after rolling over from all-ones.
module first_counter
    import first_counter_pkg::*;
#(
    parameter int WIDTH = FIRST_COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter_out,
    output logic             overflow_out
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             carry;
    logic             overflow_q;
    logic             overflow_d;

    first_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .reset_n_i   (reset),
        .enable_i    (enable),
        .count_o     (count),
        .count_next_o(count_next),
        .carry_o     (carry)
    );

    // A wrap happens only on an enabled edge taken from all-ones; any other
    // edge, including a disabled one at all-ones, clears the pulse.
    always_comb begin
        overflow_d = enable & carry;
    end

    // Overflow pulse register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign counter_out  = count;
    assign overflow_out = overflow_q;

    // count_next is only needed inside the core; referenced here so the
    // port stays connected without an unused-signal warning.
    logic unused_count_next;
    assign unused_count_next = ^count_next;

endmodule : first_counter

// File: tb/tb_first_counter.sv
// Directed bench for first_counter at the default width of 4.
module tb_first_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] counter_out;
    logic       overflow_out;

    int n_cmp;
    int n_err;
    int pulses;

    first_counter #(
        .WIDTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .counter_out (counter_out),
        .overflow_out(overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_both(input string tag, input int exp_cnt, input int exp_ovf);
        check({tag, "_cnt"}, int'(counter_out), exp_cnt);
        check({tag, "_ovf"}, int'(overflow_out), exp_ovf);
        $display("%s: counter_out=%0d overflow_out=%0d", tag, counter_out, overflow_out);
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        pulses = 0;
        reset  = 1'b1;
        enable = 1'b1;

        // Reset: asynchronous clear before the first edge, then held over edges.
        #2 reset = 1'b0;
        #1 check_both("reset_async", 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_both("reset_held", 0, 0);
        end

        // Basic count: 1 through 10, then hold at 10.
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_both("basic_count", i, 0);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_both("basic_hold", 10, 0);
        end

        // Wrap: 100 enabled edges from reset, pulse on every 16th edge.
        reset = 1'b0;
        #1 check_both("wrap_reset", 0, 0);
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (overflow_out === 1'b1) pulses++;
            check_both("wrap_run", i % 16, (i % 16 == 0) ? 1 : 0);
        end
        check("wrap_final_cnt", int'(counter_out), 4);
        check("wrap_pulse_count", pulses, 6);

        // Hold at all-ones: count 4 -> 15, pause, then wrap.
        for (int i = 5; i <= 15; i++) begin
            step();
            check_both("to_ones", i, 0);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_both("hold_ones", 15, 0);
        end
        enable = 1'b1;
        step();
        check_both("rewrap", 0, 1);
        step();
        check_both("after_rewrap", 1, 0);

        // Mid-operation reset at count 7, then restart at 1.
        for (int i = 2; i <= 7; i++) begin
            step();
        end
        check_both("at_seven", 7, 0);
        #2 reset = 1'b0;
        #1 check_both("mid_reset_async", 0, 0);
        step();
        check_both("mid_reset_held", 0, 0);
        reset = 1'b1;
        step();
        check_both("mid_restart", 1, 0);

        // Pulse cleared by reset: reach the wrap, then reset inside the pulse.
        for (int i = 2; i <= 15; i++) begin
            step();
        end
        check_both("pre_pulse", 15, 0);
        step();
        check_both("pulse", 0, 1);
        #2 reset = 1'b0;
        #1 check_both("pulse_reset_async", 0, 0);
        step();
        reset = 1'b1;
        step();
        check_both("pulse_restart", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_first_counter
